// File: rtl/bsg_link_pkg.sv
// rtl/bsg_link_pkg.sv - shared widths and beat type for the two-channel off-chip link
// Contents: channel/core widths, beats per core word, link_beat_t (one beat on both channels).
package bsg_link_pkg;

    localparam int LINK_CH_W     = 8;
    localparam int LINK_CHANNELS = 2;
    localparam int CORE_W        = 64;
    localparam int BEAT_W        = LINK_CH_W * LINK_CHANNELS;
    localparam int BEATS         = CORE_W / BEAT_W;

    // ch1 sits in the upper byte so a beat packs as {ch1, ch0}.
    typedef struct packed {
        logic [LINK_CH_W-1:0] ch1;
        logic [LINK_CH_W-1:0] ch0;
    } link_beat_t;

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// rtl/bsg_link_rx_fifo.sv - credit-sized word FIFO for the link receiver
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears pointers)
//   wr_en, wr_data      enqueue; caller only writes when !full or a read happens the same cycle
//   full                all DEPTH entries occupied
//   rd_en               dequeue the head; caller only reads when !empty
//   empty, head_data    no entries / current head word (0 when empty)
module bsg_link_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full with a simultaneous read, the write lands in the slot being
    // read out this cycle; the reader has already taken the old value.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bsg_downstream_ch_rx.sv
// rtl/bsg_downstream_ch_rx.sv - link receive end: beat assembly, word FIFO, credit token return
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   io_valid_i                    beat present on both channels
//   io_data_ch0_i, io_data_ch1_i  channel beat data (ch0 low byte, ch1 high byte of each beat)
//   io_token_o                    toggles once per TOKEN_RATIO dequeued words
//   core_valid_o, core_data_o     FIFO head word and its valid
//   core_yumi_i                   core consumes the head word
//   overflow_o                    sticky: a word completed while the FIFO was full and not draining
module bsg_downstream_ch_rx
    import bsg_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int TOKEN_RATIO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_valid_i,
    input  logic [LINK_CH_W-1:0] io_data_ch0_i,
    input  logic [LINK_CH_W-1:0] io_data_ch1_i,
    output logic              io_token_o,
    output logic              core_valid_o,
    output logic [CORE_W-1:0] core_data_o,
    input  logic              core_yumi_i,
    output logic              overflow_o
);

    localparam int BW = $clog2(BEATS);
    localparam int TW = $clog2(TOKEN_RATIO);

    logic [BW-1:0]     beat_ctr;
    logic [CORE_W-1:0] asm_word;
    logic [CORE_W-1:0] word_full;
    logic [TW-1:0]     tok_ctr;
    link_beat_t        beat;
    logic              word_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic              deq;
    logic              enq;

    assign beat.ch0 = io_data_ch0_i;
    assign beat.ch1 = io_data_ch1_i;

    // Assembly register merged with the current beat, so the last beat of a
    // word goes straight into the FIFO without an extra cycle.
    always_comb begin
        word_full = asm_word;
        word_full[beat_ctr*BEAT_W +: BEAT_W] = beat;
    end

    assign word_done = io_valid_i && (beat_ctr == BW'(BEATS - 1));
    assign deq       = core_yumi_i && !fifo_empty;
    // A full FIFO still accepts a word when the core frees a slot the same cycle.
    assign enq       = word_done && (!fifo_full || deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_ctr <= '0;
            asm_word <= '0;
        end else if (io_valid_i) begin
            beat_ctr <= beat_ctr + 1'b1;
            asm_word <= word_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (word_done && fifo_full && !deq) begin
            overflow_o <= 1'b1;
        end
    end

    // Residual credits below TOKEN_RATIO stay in tok_ctr until enough accrue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_ctr    <= '0;
            io_token_o <= 1'b0;
        end else if (deq) begin
            tok_ctr <= tok_ctr + 1'b1;
            if (tok_ctr == TW'(TOKEN_RATIO - 1)) io_token_o <= ~io_token_o;
        end
    end

    bsg_link_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CORE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (enq),
        .wr_data   (word_full),
        .full      (fifo_full),
        .rd_en     (deq),
        .empty     (fifo_empty),
        .head_data (core_data_o)
    );

    assign core_valid_o = !fifo_empty;

endmodule

// File: tb/tb_bsg_downstream_ch_rx.sv
// tb/tb_bsg_downstream_ch_rx.sv - self-checking bench for bsg_downstream_ch_rx
module tb_bsg_downstream_ch_rx;

    localparam int DEPTH = 16;
    localparam int RATIO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_valid_i = 1'b0;
    logic [7:0]  io_data_ch0_i = '0;
    logic [7:0]  io_data_ch1_i = '0;
    logic        io_token_o;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i = 1'b0;
    logic        overflow_o;

    bsg_downstream_ch_rx #(.FIFO_DEPTH(DEPTH), .TOKEN_RATIO(RATIO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_valid_i    (io_valid_i),
        .io_data_ch0_i (io_data_ch0_i),
        .io_data_ch1_i (io_data_ch1_i),
        .io_token_o    (io_token_o),
        .core_valid_o  (core_valid_o),
        .core_data_o   (core_data_o),
        .core_yumi_i   (core_yumi_i),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of whole words, queue of pending beats, dequeue count.
    logic [63:0] model_q[$];
    logic [15:0] beat_q[$];
    int          deq_count;
    bit          model_ovf;
    logic [63:0] last_pop;
    // Upstream side: credits and observed token toggles.
    int          credits;
    int          toggles;
    logic        tok_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        beat_q.delete();
        deq_count = 0;
        model_ovf = 1'b0;
        last_pop  = '0;
        credits   = DEPTH;
        toggles   = 0;
        tok_prev  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("core_valid", core_valid_o, model_q.size() != 0);
        chk("core_data", core_data_o, (model_q.size() != 0) ? model_q[0] : 64'h0);
        chk("io_token", io_token_o, ((deq_count / RATIO) % 2) != 0);
        chk("overflow", overflow_o, model_ovf);
    endtask

    // ymode: 0 never consume, 1 consume whenever a word is visible, 2 randomly consume.
    task automatic step(input bit v, input logic [15:0] b, input int ymode);
        bit y;
        bit complete;
        logic [63:0] w;
        @(negedge clk);
        check_outputs();
        if (io_token_o !== tok_prev) begin
            toggles++;
            credits += RATIO;
            tok_prev = io_token_o;
        end
        y = (model_q.size() != 0) && ((ymode == 1) || (ymode == 2 && $urandom_range(0, 1) == 1));
        io_valid_i    = v;
        io_data_ch0_i = b[7:0];
        io_data_ch1_i = b[15:8];
        core_yumi_i   = y;
        @(posedge clk);
        complete = 1'b0;
        w = '0;
        if (v) begin
            beat_q.push_back(b);
            if (beat_q.size() == 4) begin
                w = {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};
                beat_q.delete();
                complete = 1'b1;
            end
        end
        if (y) begin
            last_pop = model_q.pop_front();
            deq_count++;
        end
        if (complete) begin
            if (model_q.size() < DEPTH) model_q.push_back(w);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n, input int ymode);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, ymode);
    endtask

    task automatic send_word(input logic [63:0] w, input int ymode, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap), ymode);
            step(1'b1, w[16*k +: 16], ymode);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sent[$];
        logic [63:0] w;
        int n;

        model_reset();
        do_reset();
        chk("reset_valid", core_valid_o, 64'h0);
        chk("reset_data", core_data_o, 64'h0);
        chk("reset_token", io_token_o, 64'h0);
        chk("reset_overflow", overflow_o, 64'h0);

        // 1: single word, visible one cycle after last beat, then consumed.
        step(1'b1, 16'h1100, 0);
        step(1'b1, 16'h3322, 0);
        step(1'b1, 16'h5544, 0);
        step(1'b1, 16'h7766, 0);
        @(negedge clk);
        chk("t1_valid", core_valid_o, 64'h1);
        chk("t1_data", core_data_o, 64'h7766554433221100);
        step(1'b0, 16'h0, 1);
        idle(1, 0);
        chk("t1_empty", core_valid_o, 64'h0);

        // 2: 16 back-to-back words with eager consumption; token toggles twice.
        do_reset();
        for (int i = 0; i < 16; i++) send_word({$urandom, $urandom}, 1, 0);
        while (model_q.size() != 0) step(1'b0, 16'h0, 1);
        idle(2, 0);
        chk("t2_dequeues", deq_count, 64'd16);
        chk("t2_toggles", toggles, 64'd2);
        chk("t2_token", io_token_o, 64'h0);

        // 3: fill, overflow on the 17th word, drain in order.
        do_reset();
        sent.delete();
        for (int i = 0; i < 17; i++) begin
            w = {$urandom, $urandom};
            sent.push_back(w);
            send_word(w, 0, 0);
        end
        idle(1, 0);
        chk("t3_overflow", overflow_o, 64'h1);
        n = 0;
        while (model_q.size() != 0) begin
            step(1'b0, 16'h0, 1);
            n++;
        end
        idle(1, 0);
        chk("t3_drained", n, 64'd16);
        chk("t3_last", last_pop, sent[15]);

        // 4: full FIFO, 17th word completes together with a consume.
        do_reset();
        sent.delete();
        for (int i = 0; i < 17; i++) begin
            w = {$urandom, $urandom};
            sent.push_back(w);
        end
        for (int i = 0; i < 16; i++) send_word(sent[i], 0, 0);
        w = sent[16];
        step(1'b1, w[15:0], 0);
        step(1'b1, w[31:16], 0);
        step(1'b1, w[47:32], 0);
        step(1'b1, w[63:48], 1);
        idle(1, 0);
        chk("t4_overflow", overflow_o, 64'h0);
        chk("t4_count", model_q.size(), 64'd16);
        while (model_q.size() != 0) step(1'b0, 16'h0, 1);
        idle(1, 0);
        chk("t4_last", last_pop, sent[16]);

        // 5: random gaps between beats, then reset in the middle of a word.
        do_reset();
        for (int i = 0; i < 6; i++) send_word({$urandom, $urandom}, 2, 3);
        while (model_q.size() != 0) step(1'b0, 16'h0, 1);
        send_word(64'hDEAD_BEEF_0123_4567, 0, 0);
        step(1'b1, 16'hAAAA, 0);
        step(1'b1, 16'hBBBB, 0);
        @(negedge clk);
        io_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", core_valid_o, 64'h0);
        chk("t5_rst_data", core_data_o, 64'h0);
        chk("t5_rst_token", io_token_o, 64'h0);
        chk("t5_rst_overflow", overflow_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send_word(64'h0F0E_0D0C_0B0A_0908, 0, 0);
        @(negedge clk);
        chk("t5_clean_word", core_data_o, 64'h0F0E_0D0C_0B0A_0908);
        step(1'b0, 16'h0, 1);

        // 6: random traffic limited by upstream credits.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit v;
            v = ((beat_q.size() != 0) || (credits > 0)) && ($urandom_range(0, 3) != 0);
            if (v && beat_q.size() == 0) credits--;
            step(v, 16'($urandom), 2);
        end
        while (beat_q.size() != 0) step(1'b1, 16'($urandom), 2);
        while (model_q.size() != 0) step(1'b0, 16'h0, 1);
        idle(2, 0);
        chk("t6_overflow", overflow_o, 64'h0);
        chk("t6_toggles", toggles, deq_count / RATIO);
        chk("t6_credits", credits, DEPTH - (deq_count % RATIO));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
